clock_time_ctrl: RTL and testbench

- Timekeeping and set-mode controller for the HH:MM:SS clock.
- Generates the once-per-second tick and maintains the seconds, minutes and hours counters.
- Runs a user set-mode FSM from two pre-debounced button pulses.
- Drives the 6-bit binary values consumed by the per-pair seven-segment decoders, plus blank controls that blink the field being edited.

---
 rtl/clock_time_ctrl.sv | 146 ++++++++++++++
 tb/tb_clock_time_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_ctrl.sv
// ---------------------------------------------------------------------------
// clock_time_ctrl
//   Timekeeping and set-mode controller for an HH:MM:SS clock. A prescaler
//   produces a once-per-second tick that advances the time in RUN mode. Two
//   debounced button pulses drive a small FSM that lets the user edit the
//   hours and then the minutes. The field being edited blinks at 1 Hz.
//
// Parameters
//   TICK_DIV   clk cycles per second (even, >= 2)
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   mode_btn   one-cycle pulse: RUN -> SET_HR -> SET_MIN -> RUN
//   inc_btn    one-cycle pulse: increments the field being edited
//   sec        seconds 0..59 (binary)
//   min        minutes 0..59 (binary)
//   hr         hours   0..23 (binary)
//   hr_blank   1 = hours display pair blanked (blink while editing hours)
//   min_blank  1 = minutes display pair blanked (blink while editing minutes)
//   mode       FSM state: 00 RUN, 01 SET_HR, 10 SET_MIN
//   sec_tick   one-cycle pulse on every one-second tick
// ---------------------------------------------------------------------------
module clock_time_ctrl #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [5:0] hr,
    output logic       hr_blank,
    output logic       min_blank,
    output logic [1:0] mode,
    output logic       sec_tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(TICK_DIV / 2);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    sec_q, sec_d;
    logic [5:0]    min_q, min_d;
    logic [5:0]    hr_q, hr_d;
    logic          tick_q, tick_d;
    logic          hr_blank_q, hr_blank_d;
    logic          min_blank_q, min_blank_d;
    logic          wrap;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        wrap    = (cnt_q == CNT_LAST);
        cnt_d   = wrap ? '0 : cnt_q + 1'b1;
        tick_d  = wrap;
        state_d = state_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hr_d    = hr_q;

        case (state_q)
            RUN: begin
                if (mode_btn) state_d = SET_HR;
                // Full 23:59:59 -> 00:00:00 carry resolves in this one cycle.
                if (wrap) begin
                    if (sec_q == 6'd59) begin
                        sec_d = '0;
                        if (min_q == 6'd59) begin
                            min_d = '0;
                            hr_d  = (hr_q == 6'd23) ? 6'd0 : hr_q + 6'd1;
                        end else begin
                            min_d = min_q + 6'd1;
                        end
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end
            end
            SET_HR: begin
                // mode_btn wins over a simultaneous inc_btn.
                if (mode_btn)     state_d = SET_MIN;
                else if (inc_btn) hr_d = (hr_q == 6'd23) ? 6'd0 : hr_q + 6'd1;
            end
            SET_MIN: begin
                if (mode_btn) begin
                    // Restart the second cleanly so the first tick after
                    // leaving set mode is a full second away.
                    state_d = RUN;
                    sec_d   = '0;
                    cnt_d   = '0;
                end else if (inc_btn) begin
                    min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                end
            end
            default: state_d = RUN;
        endcase

        // Blink phase is the upper half of the second; gated by the state
        // being entered so a blank never survives into RUN.
        hr_blank_d  = (state_d == SET_HR)  && (cnt_q >= CNT_HALF);
        min_blank_d = (state_d == SET_MIN) && (cnt_q >= CNT_HALF);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together from values sampled at the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            sec_q       <= '0;
            min_q       <= '0;
            hr_q        <= '0;
            tick_q      <= 1'b0;
            hr_blank_q  <= 1'b0;
            min_blank_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hr_q        <= hr_d;
            tick_q      <= tick_d;
            hr_blank_q  <= hr_blank_d;
            min_blank_q <= min_blank_d;
        end
    end

    assign sec       = sec_q;
    assign min       = min_q;
    assign hr        = hr_q;
    assign mode      = state_q;
    assign sec_tick  = tick_q;
    assign hr_blank  = hr_blank_q;
    assign min_blank = min_blank_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clock_time_ctrl
//   Directed bench for clock_time_ctrl with TICK_DIV=4. Stimulus pushes
//   expected observations (tagged with the clock edge after which they must
//   hold) into a scoreboard; a monitor pops and compares them shortly after
//   each rising edge.
// ---------------------------------------------------------------------------
module tb_clock_time_ctrl;

    localparam int unsigned DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mode_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic [5:0] sec, min, hr;
    logic       hr_blank, min_blank, sec_tick;
    logic [1:0] mode;

    clock_time_ctrl #(.TICK_DIV(DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode_btn  (mode_btn),
        .inc_btn   (inc_btn),
        .sec       (sec),
        .min       (min),
        .hr        (hr),
        .hr_blank  (hr_blank),
        .min_blank (min_blank),
        .mode      (mode),
        .sec_tick  (sec_tick)
    );

    always #5 clk = ~clk;

    // care bits: 0 time, 1 mode, 2 blanks, 3 tick
    typedef struct {
        int         cyc;
        string      name;
        logic [3:0] care;
        int         h, m, s, md;
        bit         hb, mb, tk;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;      // rising edges seen so far
    int   base = 0;     // edge after which the prescaler read 0
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %0d, expected %0d", nm, cyc, act, req);
        end
    endtask

    // Monitor: compare every expectation due at this edge.
    always begin
        @(posedge clk);
        cyc = cyc + 1;
        #2;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            if (mon_e.cyc < cyc) begin
                check({mon_e.name, "_stale"}, mon_e.cyc, cyc);
            end else begin
                if (mon_e.care[0]) begin
                    check({mon_e.name, ".hr"},  int'(hr),  mon_e.h);
                    check({mon_e.name, ".min"}, int'(min), mon_e.m);
                    check({mon_e.name, ".sec"}, int'(sec), mon_e.s);
                end
                if (mon_e.care[1]) check({mon_e.name, ".mode"}, int'(mode), mon_e.md);
                if (mon_e.care[2]) begin
                    check({mon_e.name, ".hr_blank"},  int'(hr_blank),  int'(mon_e.hb));
                    check({mon_e.name, ".min_blank"}, int'(min_blank), int'(mon_e.mb));
                end
                if (mon_e.care[3]) check({mon_e.name, ".sec_tick"}, int'(sec_tick), int'(mon_e.tk));
            end
        end
    end

    task automatic push(input int dc, input string nm, input logic [3:0] care,
                        input int h, input int m, input int s, input int md,
                        input bit hb, input bit mb, input bit tk);
        exp_t e;
        int   idx;
        e.cyc = cyc + dc; e.name = nm; e.care = care;
        e.h = h; e.m = m; e.s = s; e.md = md; e.hb = hb; e.mb = mb; e.tk = tk;
        idx = sb.size();
        while (idx > 0 && sb[idx-1].cyc > e.cyc) idx--;
        sb.insert(idx, e);
    endtask

    task automatic exp_time(input int dc, input string nm, input int h, input int m, input int s);
        push(dc, nm, 4'b0001, h, m, s, 0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic exp_mode(input int dc, input string nm, input int md);
        push(dc, nm, 4'b0010, 0, 0, 0, md, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic exp_blank(input int dc, input string nm, input bit hb, input bit mb);
        push(dc, nm, 4'b0100, 0, 0, 0, 0, hb, mb, 1'b0);
    endtask
    task automatic exp_tick(input int dc, input string nm, input bit tk);
        push(dc, nm, 4'b1000, 0, 0, 0, 0, 1'b0, 1'b0, tk);
    endtask

    // Prescaler expectations derived from the last clear point.
    function automatic bit tick_at(input int e);
        return (e > base) && (((e - base) % DIV) == 0);
    endfunction
    // Blank after edge e reflects the prescaler value before e (>= DIV/2).
    function automatic bit phase_at(input int e);
        return (((e - 1 - base) % DIV) >= DIV / 2);
    endfunction

    // Drive one cycle of buttons from a falling edge; return one cycle later.
    task automatic btn(input bit m, input bit i);
        mode_btn = m;
        inc_btn  = i;
        @(negedge clk);
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
    endtask

    task automatic wait_no_tick();
        while (tick_at(cyc + 1)) @(negedge clk);
    endtask

    task automatic run_ticks(input int n);
        int k = 0;
        while (k < n) begin
            @(negedge clk);
            if (tick_at(cyc)) k++;
        end
    endtask

    initial begin
        // Reset held for edges 1..3.
        exp_time(2, "rst_hold", 0, 0, 0);
        exp_mode(2, "rst_hold", 0);
        exp_blank(3, "rst_hold", 1'b0, 1'b0);
        exp_tick(3, "rst_hold", 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        base  = cyc;
        exp_time(1, "rst_rel", 0, 0, 0);
        exp_mode(1, "rst_rel", 0);
        exp_blank(1, "rst_rel", 1'b0, 1'b0);
        for (int d = 1; d <= 8; d++) exp_tick(d, "tick_period", (d % 4) == 0);
        exp_time(4, "first_tick", 0, 0, 1);
        exp_time(8, "second_tick", 0, 0, 2);
        repeat (8) @(negedge clk);

        // Run up to 00:00:37.
        run_ticks(35);
        exp_time(1, "run_37", 0, 0, 37);

        // SET_HR: 25 increments wrap 23 -> 0 and land on 1; time frozen.
        wait_no_tick();
        exp_mode(1, "enter_set_hr", 1);
        btn(1'b1, 1'b0);
        for (int k = 1; k <= 25; k++) begin
            exp_time(1, "set_hr_inc", k % 24, 0, 37);
            btn(1'b0, 1'b1);
        end
        for (int d = 1; d <= 4; d++) begin
            exp_blank(d, "hr_blink", phase_at(cyc + d), 1'b0);
            exp_time(d, "set_hr_frozen", 1, 0, 37);
        end
        repeat (4) @(negedge clk);

        // mode+inc together in SET_HR: mode wins, hr unchanged.
        exp_mode(1, "both_set_hr", 2);
        exp_time(1, "both_set_hr", 1, 0, 37);
        btn(1'b1, 1'b1);

        // SET_MIN: 59 -> 0 with no carry into hr.
        for (int k = 1; k <= 60; k++) begin
            exp_time(1, "set_min_inc", 1, k % 60, 37);
            btn(1'b0, 1'b1);
        end
        for (int d = 1; d <= 4; d++) begin
            exp_blank(d, "min_blink", 1'b0, phase_at(cyc + d));
            exp_mode(d, "min_blink", 2);
        end
        repeat (4) @(negedge clk);

        // Exit SET_MIN with sec=37: sec and prescaler clear together.
        wait_no_tick();
        exp_mode(1, "exit_set_min", 0);
        exp_time(1, "exit_set_min", 1, 0, 0);
        exp_blank(1, "exit_set_min", 1'b0, 1'b0);
        for (int d = 2; d <= 5; d++) exp_tick(d, "exit_tick", d == 5);
        exp_blank(3, "run_blank", 1'b0, 1'b0);
        exp_time(5, "exit_first_tick", 1, 0, 1);
        btn(1'b1, 1'b0);
        base = cyc;
        repeat (4) @(negedge clk);

        // Force 23:59:58 through set mode, then run across midnight.
        wait_no_tick();
        exp_mode(1, "f_set_hr", 1);
        btn(1'b1, 1'b0);
        for (int k = 1; k <= 22; k++) begin
            exp_time(1, "f_hr", 1 + k, 0, 1);
            btn(1'b0, 1'b1);
        end
        exp_mode(1, "f_set_min", 2);
        btn(1'b1, 1'b0);
        for (int k = 1; k <= 59; k++) begin
            exp_time(1, "f_min", 23, k, 1);
            btn(1'b0, 1'b1);
        end
        wait_no_tick();
        exp_time(1, "f_exit", 23, 59, 0);
        btn(1'b1, 1'b0);
        base = cyc;
        run_ticks(58);
        exp_time(1, "pre_midnight", 23, 59, 58);
        exp_time(4, "t_235959", 23, 59, 59);
        exp_time(7, "hold_235959", 23, 59, 59);
        exp_time(8, "midnight", 0, 0, 0);
        exp_tick(8, "midnight", 1'b1);
        repeat (8) @(negedge clk);

        // mode+inc together in RUN: enter SET_HR, nothing increments.
        wait_no_tick();
        exp_mode(1, "both_run", 1);
        exp_time(1, "both_run", 0, 0, 0);
        btn(1'b1, 1'b1);

        // Build 12:34:56, enter SET_MIN, then reset mid-edit.
        for (int k = 1; k <= 12; k++) begin
            exp_time(1, "g_hr", k, 0, 0);
            btn(1'b0, 1'b1);
        end
        btn(1'b1, 1'b0);
        for (int k = 1; k <= 34; k++) begin
            exp_time(1, "g_min", 12, k, 0);
            btn(1'b0, 1'b1);
        end
        wait_no_tick();
        exp_mode(1, "g_exit", 0);
        btn(1'b1, 1'b0);
        base = cyc;
        run_ticks(56);
        exp_time(1, "g_123456", 12, 34, 56);
        wait_no_tick();
        exp_mode(1, "g_set_hr", 1);
        btn(1'b1, 1'b0);
        exp_mode(1, "g_set_min", 2);
        btn(1'b1, 1'b0);
        while (!phase_at(cyc + 1)) @(negedge clk);
        exp_blank(1, "g_blank_on", 1'b0, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        exp_time(1, "mid_reset", 0, 0, 0);
        exp_mode(1, "mid_reset", 0);
        exp_blank(1, "mid_reset", 1'b0, 1'b0);
        exp_tick(1, "mid_reset", 1'b0);
        @(negedge clk);
        reset = 1'b0;
        base  = cyc;
        exp_tick(4, "post_reset_tick", 1'b1);
        exp_time(4, "post_reset_tick", 0, 0, 1);
        repeat (6) @(negedge clk);

        check("sb_drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
